// File: rtl/stk_pkg.sv
// stk_pkg: shared opcode encoding, FSM states and per-opcode stack requirements
// for the stk_exec Forth primitive executor.
package stk_pkg;

    // 4-bit primitive opcodes. B is MUL only when STK_MUL_EN is defined;
    // C..F are always illegal.
    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_LIT  = 4'h1,
        OP_DUP  = 4'h2,
        OP_DROP = 4'h3,
        OP_SWAP = 4'h4,
        OP_OVER = 4'h5,
        OP_ADD  = 4'h6,
        OP_SUB  = 4'h7,
        OP_AND  = 4'h8,
        OP_OR   = 4'h9,
        OP_XOR  = 4'hA,
        OP_MUL  = 4'hB
    } op_e;

    // SWP: second cycle of SWAP (push saved TOS). MULW: product write-back.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SWP  = 2'd1,
        MULW = 2'd2
    } state_e;

    // Minimum item count (TOS included) an opcode needs before it may run.
    function automatic logic [1:0] op_need(input logic [3:0] op);
        logic [1:0] n;
        n = 2'd0;
        case (op)
            OP_DUP, OP_DROP: n = 2'd1;
            OP_SWAP, OP_OVER, OP_ADD, OP_SUB,
            OP_AND, OP_OR, OP_XOR, OP_MUL: n = 2'd2;
            default: n = 2'd0;
        endcase
        return n;
    endfunction

    // Opcodes whose net effect adds one item; these are refused when full.
    function automatic logic op_grows(input logic [3:0] op);
        return (op == OP_LIT) || (op == OP_DUP) || (op == OP_OVER);
    endfunction

endpackage

// File: rtl/stk_alu.sv
// stk_alu: combinational two-operand ALU for the binary stack primitives.
// a is NOS, b is TOS; SUB yields a - b. Arithmetic wraps modulo 2^DSZ.
module stk_alu
    import stk_pkg::*;
#(
    parameter int DSZ = 32
) (
    input  logic [DSZ-1:0] a,
    input  logic [DSZ-1:0] b,
    input  logic [3:0]     op,
    output logic [DSZ-1:0] result
);

    // Select the operation; non-ALU opcodes give zero (the executor ignores it).
    always_comb begin
        result = '0;
        case (op)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/stk_exec.sv
// stk_exec: Forth primitive executor in front of the data stack block.
// TOS lives here; NOS and deeper cells live downstream behind ss_push/ss_pop.
// Handshake: an opcode is taken on a rising edge where op_valid && op_ready;
// op and lit are sampled on that edge. op_ready is high only in IDLE and
// op_valid may be held or dropped freely while op_ready is low.
// Optional feature macro: STK_MUL_EN (opcode B = two-cycle MUL).
module stk_exec
    import stk_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int DSZ   = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         op_valid,
    output logic                         op_ready,
    input  logic [3:0]                   op,
    input  logic [DSZ-1:0]               lit,
    output logic [DSZ-1:0]               tos,
    output logic [$clog2(DEPTH+2)-1:0]   depth,
    output logic                         ss_push,
    output logic                         ss_pop,
    output logic [DSZ-1:0]               ss_vi,
    input  logic [DSZ-1:0]               ss_s0,
    output logic                         err_uf,
    output logic                         err_of,
    output logic                         err_ill
);

    localparam int DW = $clog2(DEPTH + 2);
    localparam logic [DW-1:0] DEPTH_MAX = DW'(DEPTH + 1);
    localparam logic [DW-1:0] ONE       = DW'(1);
    localparam logic [DW-1:0] TWO       = DW'(2);

    state_e         state_q, state_d;
    logic [DSZ-1:0] tos_q, tos_d;
    logic [DSZ-1:0] tmp_q, tmp_d;
    logic [DW-1:0]  depth_q, depth_d;
    logic           err_uf_q, err_uf_d;
    logic           err_of_q, err_of_d;
    logic           err_ill_q, err_ill_d;
    logic [DSZ-1:0] alu_res;
    logic           illegal;
`ifdef STK_MUL_EN
    logic [DSZ-1:0] prod_q, prod_d;
`endif

    stk_alu #(.DSZ(DSZ)) u_alu (
        .a      (ss_s0),
        .b      (tos_q),
        .op     (op),
        .result (alu_res)
    );

    // Opcodes above the implemented range are illegal.
`ifdef STK_MUL_EN
    assign illegal = (op > OP_MUL);
`else
    assign illegal = (op > OP_XOR);
`endif

    // State register; reset also drops any half-finished SWAP/MUL.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            tos_q     <= '0;
            tmp_q     <= '0;
            depth_q   <= '0;
            err_uf_q  <= 1'b0;
            err_of_q  <= 1'b0;
            err_ill_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tos_q     <= tos_d;
            tmp_q     <= tmp_d;
            depth_q   <= depth_d;
            err_uf_q  <= err_uf_d;
            err_of_q  <= err_of_d;
            err_ill_q <= err_ill_d;
        end
    end

`ifdef STK_MUL_EN
    // Product register between the MUL issue cycle and the write-back cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prod_q <= '0;
        else        prod_q <= prod_d;
    end
`endif

    // Next-state, stack strobes and error detection. Strobes are issued in the
    // accept cycle; at most one of push/pop is raised in any branch.
    always_comb begin
        state_d   = state_q;
        tos_d     = tos_q;
        tmp_d     = tmp_q;
        depth_d   = depth_q;
        err_uf_d  = err_uf_q;
        err_of_d  = err_of_q;
        err_ill_d = err_ill_q;
        ss_push   = 1'b0;
        ss_pop    = 1'b0;
        ss_vi     = tos_q;
        op_ready  = (state_q == IDLE);
`ifdef STK_MUL_EN
        prod_d    = prod_q;
`endif
        case (state_q)
            IDLE: begin
                if (op_valid) begin
                    if (illegal) begin
                        err_ill_d = 1'b1;
                    end else if (depth_q < DW'(op_need(op))) begin
                        err_uf_d = 1'b1;
                    end else if (op_grows(op) && (depth_q == DEPTH_MAX)) begin
                        err_of_d = 1'b1;
                    end else begin
                        case (op)
                            OP_LIT: begin
                                // An empty executor has no TOS worth saving.
                                ss_push = (depth_q != '0);
                                tos_d   = lit;
                                depth_d = depth_q + ONE;
                            end
                            OP_DUP: begin
                                ss_push = 1'b1;
                                depth_d = depth_q + ONE;
                            end
                            OP_DROP: begin
                                // With only TOS present the stack block is empty.
                                if (depth_q >= TWO) begin
                                    ss_pop = 1'b1;
                                    tos_d  = ss_s0;
                                end else begin
                                    tos_d  = '0;
                                end
                                depth_d = depth_q - ONE;
                            end
                            OP_SWAP: begin
                                ss_pop  = 1'b1;
                                tos_d   = ss_s0;
                                tmp_d   = tos_q;
                                state_d = SWP;
                            end
                            OP_OVER: begin
                                ss_push = 1'b1;
                                tos_d   = ss_s0;
                                depth_d = depth_q + ONE;
                            end
                            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                                ss_pop  = 1'b1;
                                tos_d   = alu_res;
                                depth_d = depth_q - ONE;
                            end
`ifdef STK_MUL_EN
                            OP_MUL: begin
                                ss_pop  = 1'b1;
                                prod_d  = ss_s0 * tos_q;
                                depth_d = depth_q - ONE;
                                state_d = MULW;
                            end
`endif
                            default: ;
                        endcase
                    end
                end
            end
            SWP: begin
                ss_push = 1'b1;
                ss_vi   = tmp_q;
                state_d = IDLE;
            end
`ifdef STK_MUL_EN
            MULW: begin
                tos_d   = prod_q;
                state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    assign tos     = tos_q;
    assign depth   = depth_q;
    assign err_uf  = err_uf_q;
    assign err_of  = err_of_q;
    assign err_ill = err_ill_q;

endmodule

// File: tb/tb_stk_exec.sv
// tb_stk_exec: directed scenarios for stk_exec with a behavioural stack model
// standing in for the downstream stack block.
module tb_stk_exec;

    logic        clk;
    logic        rst_n;
    logic        op_valid;
    logic        op_ready;
    logic [3:0]  op_in;
    logic [31:0] lit_in;
    logic [31:0] tos;
    logic [4:0]  depth;
    logic        ss_push;
    logic        ss_pop;
    logic [31:0] ss_vi;
    logic [31:0] ss_s0;
    logic        err_uf;
    logic        err_of;
    logic        err_ill;

    int checks = 0;
    int errors = 0;

    stk_exec #(.DEPTH(16), .DSZ(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .op_valid (op_valid),
        .op_ready (op_ready),
        .op       (op_in),
        .lit      (lit_in),
        .tos      (tos),
        .depth    (depth),
        .ss_push  (ss_push),
        .ss_pop   (ss_pop),
        .ss_vi    (ss_vi),
        .ss_s0    (ss_s0),
        .err_uf   (err_uf),
        .err_of   (err_of),
        .err_ill  (err_ill)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Behavioural 16-cell stack behind ss_*
    logic [31:0] mem [0:15];
    int sp;
    assign ss_s0 = (sp > 0) ? mem[4'(sp - 1)] : 32'h0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp <= 0;
        end else if (ss_push || ss_pop) begin
            checks++;
            if (ss_push && ss_pop) begin
                errors++;
                $display("FAIL strobe_excl: push=%b pop=%b want not both", ss_push, ss_pop);
            end else if (ss_push && sp >= 16) begin
                errors++;
                $display("FAIL stack_full_push: sp=%0d want <16", sp);
            end else if (ss_pop && sp == 0) begin
                errors++;
                $display("FAIL stack_empty_pop: sp=%0d want >0", sp);
            end else if (ss_push) begin
                mem[4'(sp)] <= ss_vi;
                sp <= sp + 1;
            end else begin
                sp <= sp - 1;
            end
        end
    end

    // Driver: wait (bounded) for op_ready, present one opcode for one edge
    task automatic send(input logic [3:0] o, input logic [31:0] v);
        int n;
        n = 0;
        @(negedge clk);
        while (!op_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!op_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: op_ready=%b want 1", op_ready);
        end
        op_valid = 1'b1;
        op_in    = o;
        lit_in   = v;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
    endtask

    // Wait (bounded) until the executor is idle again, sampling at negedge
    task automatic settle();
        int n;
        n = 0;
        @(negedge clk);
        while (!op_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!op_ready) begin
            checks++;
            errors++;
            $display("FAIL settle_timeout: op_ready=%b want 1", op_ready);
        end
    endtask

    task automatic apply_reset();
        op_valid = 1'b0;
        op_in    = 4'h0;
        lit_in   = 32'h0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        op_valid = 1'b0;
        rst_n = 1'b0;
        #23;
        checks++;
        if ({tos, depth, err_uf, err_of, err_ill} !== {32'h0, 5'd0, 3'b000}) begin
            errors++;
            $display("FAIL reset_state: tos=%h depth=%0d errs=%b%b%b want 0 0 000",
                     tos, depth, err_uf, err_of, err_ill);
        end
        checks++;
        if ({op_ready, ss_push, ss_pop} !== 3'b100) begin
            errors++;
            $display("FAIL reset_hs: ready/push/pop=%b want 100", {op_ready, ss_push, ss_pop});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Scenario 1: LIT 3E8, LIT 3E9, ADD
    task automatic test_add();
        apply_reset();
        send(4'h1, 32'h3E8);
        send(4'h1, 32'h3E9);
        send(4'h6, 32'h0);
        settle();
        checks++;
        if (tos !== 32'h7D1) begin
            errors++;
            $display("FAIL add_tos: got %h want %h", tos, 32'h7D1);
        end
        checks++;
        if (depth !== 5'd1) begin
            errors++;
            $display("FAIL add_depth: got %0d want 1", depth);
        end
        checks++;
        if ({err_uf, err_of, err_ill} !== 3'b000) begin
            errors++;
            $display("FAIL add_errs: got %b want 000", {err_uf, err_of, err_ill});
        end
    endtask

    // Scenario 2: LIT 5, LIT 9, SWAP
    task automatic test_swap();
        apply_reset();
        send(4'h1, 32'd5);
        send(4'h1, 32'd9);
        send(4'h4, 32'h0);
        @(negedge clk);
        checks++;
        if (op_ready !== 1'b0) begin
            errors++;
            $display("FAIL swap_busy: op_ready=%b want 0", op_ready);
        end
        @(negedge clk);
        checks++;
        if (op_ready !== 1'b1) begin
            errors++;
            $display("FAIL swap_done: op_ready=%b want 1", op_ready);
        end
        checks++;
        if ({tos, ss_s0, depth} !== {32'd5, 32'd9, 5'd2}) begin
            errors++;
            $display("FAIL swap_result: tos=%0d nos=%0d depth=%0d want 5 9 2", tos, ss_s0, depth);
        end
    endtask

    // Scenario 3: LIT 7, DROP, DROP (underflow)
    task automatic test_drop_underflow();
        apply_reset();
        send(4'h1, 32'd7);
        send(4'h3, 32'h0);
        settle();
        checks++;
        if ({tos, depth, err_uf} !== {32'h0, 5'd0, 1'b0}) begin
            errors++;
            $display("FAIL drop_last: tos=%h depth=%0d uf=%b want 0 0 0", tos, depth, err_uf);
        end
        send(4'h3, 32'h0);
        settle();
        checks++;
        if ({tos, depth, err_uf} !== {32'h0, 5'd0, 1'b1}) begin
            errors++;
            $display("FAIL drop_uf: tos=%h depth=%0d uf=%b want 0 0 1", tos, depth, err_uf);
        end
    endtask

    // Scenario 4: fill to DEPTH+1, then one more LIT overflows
    task automatic test_overflow();
        apply_reset();
        for (int i = 0; i < 17; i++) send(4'h1, 32'd1000 + 32'(i));
        settle();
        checks++;
        if ({tos, depth, err_of} !== {32'd1016, 5'd17, 1'b0}) begin
            errors++;
            $display("FAIL full: tos=%0d depth=%0d of=%b want 1016 17 0", tos, depth, err_of);
        end
        send(4'h1, 32'd2000);
        settle();
        checks++;
        if ({tos, depth, err_of} !== {32'd1016, 5'd17, 1'b1}) begin
            errors++;
            $display("FAIL overflow: tos=%0d depth=%0d of=%b want 1016 17 1", tos, depth, err_of);
        end
        checks++;
        if (ss_s0 !== 32'd1015) begin
            errors++;
            $display("FAIL overflow_nos: got %0d want 1015", ss_s0);
        end
    endtask

    // Scenario 5: LIT 2, LIT 3, OVER, SUB, then illegal opcode C
    task automatic test_over_sub_ill();
        apply_reset();
        send(4'h1, 32'd2);
        send(4'h1, 32'd3);
        send(4'h5, 32'h0);
        settle();
        checks++;
        if ({tos, depth} !== {32'd2, 5'd3}) begin
            errors++;
            $display("FAIL over: tos=%0d depth=%0d want 2 3", tos, depth);
        end
        send(4'h7, 32'h0);
        settle();
        checks++;
        if ({tos, depth} !== {32'd1, 5'd2}) begin
            errors++;
            $display("FAIL sub: tos=%0d depth=%0d want 1 2", tos, depth);
        end
        send(4'hC, 32'h0);
        settle();
        checks++;
        if ({tos, depth, err_ill, err_uf, err_of} !== {32'd1, 5'd2, 3'b100}) begin
            errors++;
            $display("FAIL ill_c: tos=%0d depth=%0d ill/uf/of=%b want 1 2 100",
                     tos, depth, {err_ill, err_uf, err_of});
        end
    endtask

    // Logic ops, DUP, wrap-around SUB and DROP of a deep item
    task automatic test_logic_ops();
        apply_reset();
        send(4'h1, 32'hF0);
        send(4'h1, 32'h3C);
        send(4'h9, 32'h0);
        settle();
        checks++;
        if (tos !== 32'hFC) begin
            errors++;
            $display("FAIL or: got %h want fc", tos);
        end
        send(4'h1, 32'h0F);
        send(4'h8, 32'h0);
        settle();
        checks++;
        if (tos !== 32'h0C) begin
            errors++;
            $display("FAIL and: got %h want 0c", tos);
        end
        send(4'h1, 32'hFF);
        send(4'hA, 32'h0);
        settle();
        checks++;
        if ({tos, depth} !== {32'hF3, 5'd1}) begin
            errors++;
            $display("FAIL xor: tos=%h depth=%0d want f3 1", tos, depth);
        end
        send(4'h2, 32'h0);
        send(4'h1, 32'h0);
        send(4'h1, 32'h1);
        send(4'h7, 32'h0);
        settle();
        checks++;
        if ({tos, depth} !== {32'hFFFF_FFFF, 5'd3}) begin
            errors++;
            $display("FAIL sub_wrap: tos=%h depth=%0d want ffffffff 3", tos, depth);
        end
        send(4'h3, 32'h0);
        settle();
        checks++;
        if ({tos, depth} !== {32'hF3, 5'd2}) begin
            errors++;
            $display("FAIL drop_deep: tos=%h depth=%0d want f3 2", tos, depth);
        end
    endtask

    // Scenario 6: asynchronous reset while SWAP is in its second cycle
    task automatic test_reset_mid_swap();
        apply_reset();
        send(4'hD, 32'h0);
        send(4'h1, 32'd5);
        send(4'h1, 32'd9);
        send(4'h4, 32'h0);
        checks++;
        if ({ss_push, op_ready} !== 2'b10) begin
            errors++;
            $display("FAIL mid_swap: push/ready=%b want 10", {ss_push, op_ready});
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({tos, depth, err_uf, err_of, err_ill, op_ready, ss_push, ss_pop} !==
            {32'h0, 5'd0, 6'b000100}) begin
            errors++;
            $display("FAIL async_reset: tos=%h depth=%0d e=%b rdy/push/pop=%b want 0 0 000 100",
                     tos, depth, {err_uf, err_of, err_ill}, {op_ready, ss_push, ss_pop});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Opcode B: MUL when enabled, illegal otherwise
    task automatic test_op_b();
        apply_reset();
        send(4'h1, 32'd6);
        send(4'h1, 32'd7);
        send(4'hB, 32'h0);
`ifdef STK_MUL_EN
        @(negedge clk);
        checks++;
        if (op_ready !== 1'b0) begin
            errors++;
            $display("FAIL mul_busy: op_ready=%b want 0", op_ready);
        end
        settle();
        checks++;
        if ({tos, depth, err_ill} !== {32'h2A, 5'd1, 1'b0}) begin
            errors++;
            $display("FAIL mul: tos=%h depth=%0d ill=%b want 2a 1 0", tos, depth, err_ill);
        end
`else
        settle();
        checks++;
        if ({tos, depth, err_ill} !== {32'd7, 5'd2, 1'b1}) begin
            errors++;
            $display("FAIL op_b_ill: tos=%0d depth=%0d ill=%b want 7 2 1", tos, depth, err_ill);
        end
`endif
    endtask

    initial begin
        rst_n    = 1'b0;
        op_valid = 1'b0;
        op_in    = 4'h0;
        lit_in   = 32'h0;
        test_reset();
        test_add();
        test_swap();
        test_drop_underflow();
        test_overflow();
        test_over_sub_ill();
        test_logic_ops();
        test_reset_mid_swap();
        test_op_b();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stk_exec.md
Name: stk_exec

Overview:
- Forth primitive executor sitting directly upstream of the data stack.
- Holds TOS in a local register and accepts one opcode at a time via a valid/ready handshake.
- Sequences the stack's push/pop strobes to execute LIT, DUP, DROP, SWAP, OVER and ALU primitives.
- Consumer is the instruction decoder; NOS and deeper cells live in the stack block.

Parameters:
- DEPTH, 16, cell count of the downstream stack memory (TOS register is extra).
- DSZ, 32, data width in bits.

Ports:
- clk  in  1  system clock, all state on posedge.
- rst_n  in  1  asynchronous active-low reset.
- op_valid  in  1  opcode presented.
- op_ready  out  1  executor can accept opcode this cycle.
- op  in  4  opcode (stk_pkg::op_e).
- lit  in  DSZ  literal operand, sampled with LIT.
- tos  out  DSZ  top-of-stack register.
- depth  out  $clog2(DEPTH+2)  total items, TOS included.
- ss_push  out  1  push strobe to stack.
- ss_pop  out  1  pop strobe to stack.
- ss_vi  out  DSZ  data to push.
- ss_s0  in  DSZ  current stack top (NOS); valid combinationally.
- err_uf  out  1  sticky underflow.
- err_of  out  1  sticky overflow.
- err_ill  out  1  sticky illegal opcode.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values: tos=0, depth=0, all err_* flags=0, FSM=IDLE, ss_push=ss_pop=0, op_ready=1.
- Handshake: accept when op_valid&&op_ready; op/lit sampled on that edge. op_ready=1 only in IDLE.
- Stack side: ss_push and ss_pop are never asserted in the same cycle.
- Opcodes and effects; stack strobes are issued in the accept cycle, with one cycle of latency to the updated tos/depth:
  - NOP=0: no change.
  - LIT=1: if depth>0, push tos. tos<=lit. depth+1.
  - DUP=2: push tos. depth+1. Needs depth>=1.
  - DROP=3: tos<=ss_s0. Pop if depth>=2. depth-1. Needs depth>=1.
  - SWAP=4: two cycles. Cycle 1 (IDLE): pop, tos<=ss_s0, hold old tos in tmp, go to SWP. Cycle 2 (SWP): push tmp, return to IDLE. Needs depth>=2.
  - OVER=5: push tos, tos<=ss_s0 (pre-push value). depth+1. Needs depth>=2.
  - ADD=6/SUB=7/AND=8/OR=9/XOR=A: tos<=ss_s0 OP tos, pop, depth-1. Needs depth>=2. SUB computes NOS-TOS. Arithmetic is modulo 2^DSZ; no carry output.
  - B–F: illegal; set err_ill, no state change (B is legal only with MUL, see Optional Feature).
- Underflow: depth below the opcode's requirement. Set err_uf; opcode consumed with no change to tos/depth/stack.
- Overflow: opcode grows the stack while depth==DEPTH+1. Set err_of; no change.
- Error flags are sticky until rst_n.
- Reset mid-SWAP: FSM returns to IDLE and tmp is lost; the stack block is reset by the same rst_n.
- DROP at depth==1: tos<=0, no pop.

Optional Feature:
- Macro: STK_MUL_EN.
- Defined: opcode B=MUL, two cycles.
  - Cycle 1: register ss_s0*tos (low DSZ bits) into the product register, pop, go to MULW.
  - Cycle 2: tos<=product, return to IDLE. op_ready=0 in MULW.
  - Needs depth>=2.
- Undefined: B is illegal (sets err_ill); MULW state and multiplier are absent.

Decomposition:
- stk_pkg:
  - op_e enum (4-bit).
  - state_e {IDLE, SWP, MULW}.
  - per-opcode need/grow constants (min depth, delta).
- Sub-module stk_alu: combinational (a=NOS, b=TOS, op) -> result, covering ADD/SUB/AND/OR/XOR.
- FSM, counters and error logic stay in stk_exec.

Test Plan:
- Bench model: a behavioural stack model behind ss_*.
- Scenario 1: reset, then LIT 3E8, LIT 3E9, ADD -> tos=7D1, depth=1, err_*=0.
- Scenario 2: LIT 5, LIT 9, SWAP -> op_ready low for one cycle; then tos=5, NOS=9, depth=2.
- Scenario 3: LIT 7, DROP, DROP -> first DROP gives depth=0; second sets err_uf=1 with tos=0 and depth=0 unchanged.
- Scenario 4: 17 LITs with values 1000..1016 (DEPTH=16) -> depth=17. 18th LIT sets err_of; tos stays 1016.
- Scenario 5: LIT 2, LIT 3, OVER, SUB -> tos=1, depth=2; opcode C sets err_ill.
- Scenario 6: rst_n pulsed low mid-SWAP -> all outputs at reset values asynchronously. With STK_MUL_EN: LIT 6, LIT 7, MUL -> tos=2A after 2 cycles.
